uart_tx_serializer: RTL

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer with optional parity and 1/2 stop bits
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_baud,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS);
    localparam logic [1:0] LAST_STOP = 2'(STOP_BITS);
    localparam logic       ODD       = (PARITY_ODD != 0);

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [3:0]           bit_cnt, bit_cnt_nxt;
    logic [1:0]           stop_cnt, stop_cnt_nxt;
    logic                 parity, parity_nxt;
    logic                 serial_nxt, ready_nxt, busy_nxt, done_nxt;

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        parity_nxt   = parity;
        serial_nxt   = serial_out;
        ready_nxt    = tx_ready;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                // Parity is fixed at accept time so later tx_data changes cannot leak in.
                if (tx_valid && tx_ready) begin
                    shreg_nxt  = tx_data;
                    parity_nxt = (^tx_data) ^ ODD;
                    state_nxt  = S_WAIT;
                    ready_nxt  = 1'b0;
                    busy_nxt   = 1'b1;
                end
            end
            S_WAIT: begin
                if (clk_baud) begin
                    serial_nxt = 1'b0;
                    state_nxt  = S_START;
                end
            end
            S_START: begin
                if (clk_baud) begin
                    serial_nxt  = shreg[0];
                    shreg_nxt   = shreg >> 1;
                    bit_cnt_nxt = 4'd1;
                    state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (clk_baud) begin
                    if (bit_cnt < LAST_BIT) begin
                        serial_nxt  = shreg[0];
                        shreg_nxt   = shreg >> 1;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (PARITY_EN != 0) begin
                        serial_nxt = parity;
                        state_nxt  = S_PARITY;
                    end else begin
                        serial_nxt   = 1'b1;
                        stop_cnt_nxt = 2'd1;
                        state_nxt    = S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (clk_baud) begin
                    serial_nxt   = 1'b1;
                    stop_cnt_nxt = 2'd1;
                    state_nxt    = S_STOP;
                end
            end
            S_STOP: begin
                if (clk_baud) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_nxt    = S_IDLE;
                        ready_nxt    = 1'b1;
                        busy_nxt     = 1'b0;
                        done_nxt     = 1'b1;
                        bit_cnt_nxt  = 4'd0;
                        stop_cnt_nxt = 2'd0;
                    end else begin
                        stop_cnt_nxt = stop_cnt + 2'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= 4'd0;
            stop_cnt   <= 2'd0;
            parity     <= 1'b0;
            serial_out <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            stop_cnt   <= stop_cnt_nxt;
            parity     <= parity_nxt;
            serial_out <= serial_nxt;
            tx_ready   <= ready_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule
